// File: rtl/axi_rw_bridge_pkg.sv
// Shared encodings for the fetch/data to single-beat AXI4 bridge.
package axi_rw_bridge_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_D = 2'b11
  } size_e;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_D  = 3'd2,
    WR_AW = 3'd3,
    WR_B  = 3'd4,
    DONE  = 3'd5
  } state_e;

  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/axi_lane_align.sv
// Byte-lane alignment for a 64-bit bus: store strobes/shift and load right-justification.
module axi_lane_align (
  input  logic [2:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rdata_i,
  output logic [7:0]  strb_o,
  output logic [63:0] wdata_o,
  output logic [63:0] rdata_o
);

  logic [15:0] lane_mask;

  // Mask is built wide so a misaligned access spills past lane 7 and is dropped.
  assign lane_mask = (16'd1 << (5'd1 << size_i)) - 16'd1;
  assign strb_o    = 8'(lane_mask << off_i);
  assign wdata_o   = wdata_i << {off_i, 3'b000};
  assign rdata_o   = rdata_i >> {off_i, 3'b000};

endmodule

// File: rtl/axi_rw_bridge.sv
// Arbitrates core fetch and data requests onto one single-beat AXI4 master,
// one transaction outstanding; data requests win ties.
module axi_rw_bridge
  import axi_rw_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_valid,
  output logic                  if_ready,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic [1:0]            if_size,
  input  logic                  if_req,
  output logic [INST_WIDTH-1:0] if_data_read,
  output logic [1:0]            if_resp,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [1:0]            mem_size,
  input  logic                  mem_req,
  input  logic [DATA_WIDTH-1:0] mem_data_write,
  output logic [DATA_WIDTH-1:0] mem_data_read,
  output logic [1:0]            mem_resp,
  output logic                  axi_aw_valid,
  input  logic                  axi_aw_ready,
  output logic [ADDR_WIDTH-1:0] axi_aw_addr,
  output logic [2:0]            axi_aw_size,
  output logic                  axi_w_valid,
  input  logic                  axi_w_ready,
  output logic [DATA_WIDTH-1:0] axi_w_data,
  output logic [7:0]            axi_w_strb,
  input  logic                  axi_b_valid,
  output logic                  axi_b_ready,
  input  logic [1:0]            axi_b_resp,
  output logic                  axi_ar_valid,
  input  logic                  axi_ar_ready,
  output logic [ADDR_WIDTH-1:0] axi_ar_addr,
  output logic [2:0]            axi_ar_size,
  input  logic                  axi_r_valid,
  output logic                  axi_r_ready,
  input  logic [DATA_WIDTH-1:0] axi_r_data,
  input  logic [1:0]            axi_r_resp
);

  state_e                state_q;
  logic                  sel_mem_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  ar_valid_q, aw_valid_q, w_valid_q, b_ready_q, r_ready_q;
  logic                  aw_done_q, w_done_q;
  logic                  if_ready_q, mem_ready_q;
  logic [INST_WIDTH-1:0] if_data_q;
  logic [1:0]            if_resp_q, mem_resp_q;
  logic [DATA_WIDTH-1:0] mem_data_q;

  logic                  aw_done_d, w_done_d;
  logic [DATA_WIDTH-1:0] rdata_aligned;
  logic                  unused_if_req;

  // The fetch port is read-only; its direction bit carries no meaning here.
  assign unused_if_req = if_req;

  assign aw_done_d = aw_done_q | (aw_valid_q & axi_aw_ready);
  assign w_done_d  = w_done_q  | (w_valid_q  & axi_w_ready);

  axi_lane_align u_align (
    .off_i   (addr_q[2:0]),
    .size_i  (size_q),
    .wdata_i (wdata_q),
    .rdata_i (axi_r_data),
    .strb_o  (axi_w_strb),
    .wdata_o (axi_w_data),
    .rdata_o (rdata_aligned)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_mem_q   <= 1'b0;
      addr_q      <= '0;
      size_q      <= SIZE_B;
      wdata_q     <= '0;
      ar_valid_q  <= 1'b0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      r_ready_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_data_q   <= '0;
      if_resp_q   <= RESP_OKAY;
      mem_data_q  <= '0;
      mem_resp_q  <= RESP_OKAY;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_valid) begin
            sel_mem_q <= 1'b1;
            addr_q    <= mem_addr;
            size_q    <= mem_size;
            wdata_q   <= mem_data_write;
            if (mem_req == REQ_WRITE) begin
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              aw_done_q  <= 1'b0;
              w_done_q   <= 1'b0;
              state_q    <= WR_AW;
            end else begin
              ar_valid_q <= 1'b1;
              state_q    <= RD_A;
            end
          end else if (if_valid) begin
            sel_mem_q  <= 1'b0;
            addr_q     <= if_addr;
            size_q     <= if_size;
            ar_valid_q <= 1'b1;
            state_q    <= RD_A;
          end
        end
        RD_A: begin
          if (axi_ar_ready) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= RD_D;
          end
        end
        RD_D: begin
          if (axi_r_valid) begin
            r_ready_q <= 1'b0;
            state_q   <= DONE;
            if (sel_mem_q) begin
              mem_ready_q <= 1'b1;
              mem_data_q  <= rdata_aligned;
              mem_resp_q  <= axi_r_resp;
            end else begin
              if_ready_q <= 1'b1;
              if_data_q  <= addr_q[2] ? axi_r_data[63:32] : axi_r_data[31:0];
              if_resp_q  <= axi_r_resp;
            end
          end
        end
        WR_AW: begin
          // Each channel retires on its own handshake; b_ready waits for both.
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (aw_valid_q && axi_aw_ready) aw_valid_q <= 1'b0;
          if (w_valid_q && axi_w_ready)   w_valid_q  <= 1'b0;
          if (aw_done_d && w_done_d) begin
            b_ready_q <= 1'b1;
            state_q   <= WR_B;
          end
        end
        WR_B: begin
          if (axi_b_valid) begin
            b_ready_q   <= 1'b0;
            mem_ready_q <= 1'b1;
            mem_resp_q  <= axi_b_resp;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if_ready_q  <= 1'b0;
          mem_ready_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_ready      = if_ready_q;
  assign if_data_read  = if_data_q;
  assign if_resp       = if_resp_q;
  assign mem_ready     = mem_ready_q;
  assign mem_data_read = mem_data_q;
  assign mem_resp      = mem_resp_q;
  assign axi_aw_valid  = aw_valid_q;
  assign axi_aw_addr   = addr_q;
  assign axi_aw_size   = axi_size(size_q);
  assign axi_w_valid   = w_valid_q;
  assign axi_b_ready   = b_ready_q;
  assign axi_ar_valid  = ar_valid_q;
  assign axi_ar_addr   = addr_q;
  assign axi_ar_size   = axi_size(size_q);
  assign axi_r_ready   = r_ready_q;

endmodule
